pipe_skid_stage: RTL and testbench

- Elastic two-entry pipeline stage between adjacent SIMD pipeline stages: a main output register plus one skid register.
- Replaces a plain clocked register wherever the downstream stage can stall.
- Adds a valid/ready handshake, full throughput, registered data output and a synchronous flush for branch/hazard squash.
- Upstream stage drives in_*; downstream stage consumes out_*.

---
 rtl/pipe_skid_stage.sv | 113 +++++++++++
 tb/tb_pipe_skid_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage (main register + skid register) with valid/ready
// handshake and synchronous flush. Optional stall counter: define PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  // Encodings chosen so bit0 = main_v and bit1 = skid_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] main_d, main_d_next;
  logic [N-1:0] skid_d, skid_d_next;
  logic         main_v, skid_v;
  logic         in_fire, out_fire;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == FULL);

  // Ready depends only on held state and flush, never on out_ready.
  assign in_ready  = !skid_v && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_v && out_ready;

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_comb begin
    state_next  = state;
    main_d_next = main_d;
    skid_d_next = skid_d;
    if (flush) begin
      state_next  = EMPTY;
      main_d_next = '0;
      skid_d_next = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next  = ONE;
            main_d_next = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d_next = in_data;
          end else if (in_fire) begin
            state_next  = FULL;
            skid_d_next = in_data;
          end else if (out_fire) begin
            state_next  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_next  = ONE;
            main_d_next = skid_d;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      state  <= state_next;
      main_d <= main_d_next;
      skid_d <= skid_d_next;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [1:0] stall_inc;

  // A cycle stalled on both sides counts twice.
  assign stall_inc = {1'b0, main_v && !out_ready} + {1'b0, in_valid && !in_ready};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {30'd0, stall_inc};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage against a queue-based model of a two-deep FIFO stage.
module tb_pipe_skid_stage;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  pipe_skid_stage #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned  total = 0;
  int unsigned  bad = 0;

  logic [N-1:0] q[$];
  logic [N-1:0] last_head = '0;
  logic [31:0]  exp_stall = '0;
  bit           known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [N-1:0] d, input bit ordy);
    int unsigned sz;
    bit ifire, ofire, can_take;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    sz = q.size();
    can_take = (sz < 2) && !fl;
    if (known) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, can_take});
      check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
      check("out_data",  out_data, (sz > 0) ? q[0] : last_head);
      check("occupancy", {30'd0, occupancy}, sz);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("stall_cnt", stall_cnt, exp_stall);
`endif
    end
    ifire = iv && can_take;
    ofire = (sz > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      exp_stall = '0;
      q.delete();
      last_head = '0;
      known = 1'b1;
    end else begin
      exp_stall = exp_stall + ((sz > 0 && !ordy) ? 32'd1 : 32'd0)
                            + ((iv && !can_take) ? 32'd1 : 32'd0);
      if (fl) begin
        q.delete();
        last_head = '0;
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(d);
      end
    end
    if (q.size() > 0) last_head = q[0];
    #1;
  endtask

  initial begin
    // Reset then idle
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);

    // Streaming 1..8 back-to-back
    for (int unsigned i = 1; i <= 8; i++) step(0, 0, 1, i, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // Backpressure fill then drain in order
    step(0, 0, 1, 32'hA5A5A5A5, 0);
    step(0, 0, 1, 32'h5A5A5A5A, 0);
    step(0, 0, 1, 32'hDEADBEEF, 0);
    check("bp_occupancy", {30'd0, occupancy}, 32'd2);
    check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
    step(0, 0, 1, 32'hDEADBEEF, 0);
    step(0, 0, 1, 32'hDEADBEEF, 1);
    check("bp_second", out_data, 32'h5A5A5A5A);
    step(0, 0, 1, 32'hDEADBEEF, 1);
    check("bp_third", out_data, 32'hDEADBEEF);
    step(0, 0, 0, '0, 1);

    // Flush while FULL with in_valid high
    step(0, 0, 1, 32'h11111111, 0);
    step(0, 0, 1, 32'h22222222, 0);
    step(0, 1, 1, 32'h33333333, 0);
    check("fl_occupancy", {30'd0, occupancy}, 32'd0);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_out_data",  out_data, 32'd0);

    // Reset mid-operation from FULL with out_ready toggling
    step(0, 0, 1, 32'h44444444, 0);
    step(0, 0, 1, 32'h55555555, 0);
    step(0, 0, 1, 32'h66666666, 1);
    step(0, 0, 1, 32'h77777777, 0);
    step(1, 0, 1, 32'h88888888, 1);
    check("mr_occupancy", {30'd0, occupancy}, 32'd0);
    check("mr_out_data",  out_data, 32'd0);
    step(0, 0, 1, 32'h99999999, 0);
    check("mr_first", out_data, 32'h99999999);
    step(0, 0, 0, '0, 1);

`ifdef PIPE_SKID_STALL_CNT_EN
    // Stall counter: 5 blocked-output cycles, then double counting while FULL
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 32'hCAFE0001, 0);
    for (int unsigned i = 0; i < 5; i++) step(0, 0, 0, '0, 0);
    check("stall_five", stall_cnt, 32'd5);
    step(0, 0, 1, 32'hCAFE0002, 0);
    step(0, 0, 1, 32'hCAFE0003, 0);
    step(0, 0, 1, 32'hCAFE0003, 0);
    check("stall_double", stall_cnt, 32'd10);
    step(0, 1, 0, '0, 0);
`endif

    // Randomized traffic with occasional flush and reset
    for (int unsigned i = 0; i < 3000; i++) begin
      bit rst, fl, iv, ordy;
      rst  = ($urandom_range(0, 199) == 0);
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(rst, fl, iv, $urandom, ordy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
